// File: rtl/sobel_filter.sv
// sobel_filter: streaming 5x5 Gaussian smoothing of 24-bit RGB pixels in raster order.
// Each channel is convolved with the outer product of [1 4 6 4 1] (sum 256),
// zero padding outside the image, rounded with (sum + 128) >> 8.
//
// Ports
//   i_clk, i_rst          clock (rising edge), asynchronous active-low reset
//   i_rgb_vld/_data/_busy pixel input; [7:0]=R, [15:8]=G, [23:16]=B; busy=1 means not accepted
//   o_result_{r,g,b}_*    per-channel 8-bit results with their own vld/busy handshake
//
// After the last pixel of a frame the block runs 2*WIDTH+2 internal zero-data steps
// to push the bottom rows out. Input is refused during that flush.
module sobel_filter #(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        i_rgb_busy,
    input  logic        i_rgb_vld,
    input  logic [23:0] i_rgb_data,
    input  logic        o_result_r_busy,
    output logic        o_result_r_vld,
    output logic [7:0]  o_result_r_data,
    input  logic        o_result_g_busy,
    output logic        o_result_g_vld,
    output logic [7:0]  o_result_g_data,
    input  logic        o_result_b_busy,
    output logic        o_result_b_vld,
    output logic [7:0]  o_result_b_data
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = $clog2(HEIGHT + 3);
    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [YW-1:0] Y_FLUSH = YW'(HEIGHT);
    localparam logic [YW-1:0] Y_END   = YW'(HEIGHT + 2);

    // line_buf[k][x] holds pixel x of the row k+1 rows above the current input row
    logic [23:0]   line_buf [4][WIDTH];
    // win_p0[c][j]: column c (0 = newest), row j (0 = bottom row of the window)
    logic [23:0]   win_p0 [5][5];
    logic          vld_p0;
    logic [XW-1:0] out_x_p0;
    logic [YW-1:0] out_y_p0;

    logic [XW-1:0] in_x;
    logic [YW-1:0] in_y;

    logic [2:0]    out_vld;
    logic [2:0]    out_busy;
    logic          slot_free;
    logic          in_flush;
    logic          accept;
    logic          advance;
    logic          load;
    logic          computable;
    logic          flush_last;
    logic [23:0]   new_pix;
    logic [16:0]   acc_r;
    logic [16:0]   acc_g;
    logic [16:0]   acc_b;

    function automatic logic [16:0] gauss_w(input int i);
        case (i)
            0, 4:    return 17'd1;
            1, 3:    return 17'd4;
            default: return 17'd6;
        endcase
    endfunction

    function automatic logic [7:0] round_q8(input logic [16:0] acc);
        return 8'((acc + 17'd128) >> 8);
    endfunction

    // A tap is live only when its image coordinate lies inside the frame; this masks
    // stale line-buffer rows and columns wrapped in from the neighbouring row.
    function automatic logic tap_inside(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                        input int c, input int j);
        int tx;
        int ty;
        tx = int'(x) + 2 - c;
        ty = int'(y) + 2 - j;
        return (tx >= 0) && (tx < WIDTH) && (ty >= 0) && (ty < HEIGHT);
    endfunction

    assign out_vld  = {o_result_b_vld, o_result_g_vld, o_result_r_vld};
    assign out_busy = {o_result_b_busy, o_result_g_busy, o_result_r_busy};

    // The slot can take a new result when it is empty or all three channels drain now
    assign slot_free  = (out_vld == 3'b000) || ((out_vld & ~out_busy) == 3'b111);
    assign in_flush   = (in_y >= Y_FLUSH);
    assign accept     = slot_free && !in_flush && i_rgb_vld;
    assign advance    = accept || (slot_free && in_flush);
    assign load       = slot_free && vld_p0;
    assign i_rgb_busy = !i_rst || in_flush || !slot_free;
    assign new_pix    = accept ? i_rgb_data : 24'd0;
    // Output index lags the input index by 2*WIDTH+2
    assign computable = (in_y > YW'(2)) || ((in_y == YW'(2)) && (in_x >= XW'(2)));
    assign flush_last = (in_y == Y_END) && (in_x == XW'(1));

    always_comb begin
        acc_r = '0;
        acc_g = '0;
        acc_b = '0;
        for (int c = 0; c < 5; c++) begin
            for (int j = 0; j < 5; j++) begin
                if (tap_inside(out_x_p0, out_y_p0, c, j)) begin
                    acc_r = acc_r + gauss_w(c) * gauss_w(j) * {9'd0, win_p0[c][j][7:0]};
                    acc_g = acc_g + gauss_w(c) * gauss_w(j) * {9'd0, win_p0[c][j][15:8]};
                    acc_b = acc_b + gauss_w(c) * gauss_w(j) * {9'd0, win_p0[c][j][23:16]};
                end
            end
        end
    end

    // ---- stage p0: line buffers and 5x5 window ----
    always_ff @(posedge i_clk) begin
        if (advance) begin
            for (int k = 3; k > 0; k--) begin
                line_buf[k][in_x] <= line_buf[k-1][in_x];
            end
            line_buf[0][in_x] <= new_pix;
            for (int c = 4; c > 0; c--) begin
                for (int j = 0; j < 5; j++) begin
                    win_p0[c][j] <= win_p0[c-1][j];
                end
            end
            win_p0[0][0] <= new_pix;
            for (int k = 0; k < 4; k++) begin
                win_p0[0][k+1] <= line_buf[k][in_x];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            in_x     <= '0;
            in_y     <= '0;
            vld_p0   <= 1'b0;
            out_x_p0 <= '0;
            out_y_p0 <= '0;
        end else begin
            if (advance) begin
                if (flush_last) begin
                    in_x <= '0;
                    in_y <= '0;
                end else if (in_x == X_LAST) begin
                    in_x <= '0;
                    in_y <= in_y + YW'(1);
                end else begin
                    in_x <= in_x + XW'(1);
                end
            end
            if (slot_free) begin
                vld_p0 <= advance && computable;
            end
            if (load) begin
                if (out_x_p0 == X_LAST) begin
                    out_x_p0 <= '0;
                    out_y_p0 <= (out_y_p0 == Y_LAST) ? '0 : out_y_p0 + YW'(1);
                end else begin
                    out_x_p0 <= out_x_p0 + XW'(1);
                end
            end
        end
    end

    // ---- stage p1: output slot ----
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_result_r_vld  <= 1'b0;
            o_result_g_vld  <= 1'b0;
            o_result_b_vld  <= 1'b0;
            o_result_r_data <= '0;
            o_result_g_data <= '0;
            o_result_b_data <= '0;
        end else if (load) begin
            o_result_r_vld  <= 1'b1;
            o_result_g_vld  <= 1'b1;
            o_result_b_vld  <= 1'b1;
            o_result_r_data <= round_q8(acc_r);
            o_result_g_data <= round_q8(acc_g);
            o_result_b_data <= round_q8(acc_b);
        end else begin
            o_result_r_vld  <= o_result_r_vld && o_result_r_busy;
            o_result_g_vld  <= o_result_g_vld && o_result_g_busy;
            o_result_b_vld  <= o_result_b_vld && o_result_b_busy;
        end
    end

endmodule

// File: tb/tb_sobel_filter.sv
// Bench for sobel_filter on a 16x16 image: constant, impulse, backpressure,
// random stalls, mid-frame reset and back-to-back frames, checked against a
// direct 2D convolution of the stored image.
module tb_sobel_filter;

    localparam int W    = 16;
    localparam int H    = 16;
    localparam int N    = W * H;
    localparam int MAXF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rgb_busy;
    logic        rgb_vld;
    logic [23:0] rgb_data;
    logic [2:0]  sbusy;
    logic        o_result_r_vld, o_result_g_vld, o_result_b_vld;
    logic [7:0]  o_result_r_data, o_result_g_data, o_result_b_data;
    logic [2:0]  ovld;
    logic [7:0]  odat [3];

    int n_chk = 0;
    int n_bad = 0;

    logic [23:0] img [MAXF*N];
    logic [7:0]  got [3][MAXF*N];

    always #5 clk = ~clk;

    sobel_filter #(.WIDTH(W), .HEIGHT(H)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_rgb_busy      (rgb_busy),
        .i_rgb_vld       (rgb_vld),
        .i_rgb_data      (rgb_data),
        .o_result_r_busy (sbusy[0]),
        .o_result_r_vld  (o_result_r_vld),
        .o_result_r_data (o_result_r_data),
        .o_result_g_busy (sbusy[1]),
        .o_result_g_vld  (o_result_g_vld),
        .o_result_g_data (o_result_g_data),
        .o_result_b_busy (sbusy[2]),
        .o_result_b_vld  (o_result_b_vld),
        .o_result_b_data (o_result_b_data)
    );

    assign ovld    = {o_result_b_vld, o_result_g_vld, o_result_r_vld};
    assign odat[0] = o_result_r_data;
    assign odat[1] = o_result_g_data;
    assign odat[2] = o_result_b_data;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Direct zero-padded 5x5 convolution of frame f, channel ch at (x,y)
    function automatic int ref_out(input int ch, input int f, input int x, input int y);
        int wt [5] = '{1, 4, 6, 4, 1};
        int s;
        int xx;
        int yy;
        logic [23:0] p;
        s = 0;
        for (int dy = -2; dy <= 2; dy++) begin
            for (int dx = -2; dx <= 2; dx++) begin
                xx = x + dx;
                yy = y + dy;
                if (xx >= 0 && xx < W && yy >= 0 && yy < H) begin
                    p = img[f*N + yy*W + xx];
                    s += wt[dx+2] * wt[dy+2] * int'((p >> (8*ch)) & 24'hFF);
                end
            end
        end
        return (s + 128) >> 8;
    endfunction

    // mode 0: no stalls, 1: random stalls everywhere, 2: one 20-cycle G stall
    task automatic run_frames(input int nf, input int mode, input int abort_after);
        int total;
        int n_in;
        int n_out [3];
        int cyc;
        bit acc;
        bit done;
        bit armed;
        int flush_cnt;
        bit started;
        int st_left;
        int st_idx;
        int idx;
        int f;
        int p;
        logic [7:0] held;
        total = nf * N;
        n_in = 0;
        cyc = 0;
        acc = 0;
        done = 0;
        armed = 0;
        flush_cnt = 0;
        started = 0;
        st_left = 0;
        st_idx = 0;
        held = 8'd0;
        for (int c = 0; c < 3; c++) n_out[c] = 0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (cyc > 20000) begin
                check("timeout", cyc, 0);
                break;
            end
            if (acc) begin
                rgb_vld = 1'b0;
                acc = 0;
            end
            if (mode == 1) begin
                for (int c = 0; c < 3; c++) sbusy[c] = ($urandom_range(0, 3) == 0);
            end else begin
                if (mode == 2 && !started && cyc >= 60 && ovld[1]) begin
                    started = 1;
                    st_left = 20;
                    held = o_result_g_data;
                end
                if (st_left > 0) begin
                    sbusy = 3'b010;
                    st_idx++;
                    st_left--;
                end else begin
                    sbusy = 3'b000;
                    st_idx = 0;
                end
            end
            if (!rgb_vld && n_in < total && (abort_after == 0 || n_in < abort_after) &&
                (mode != 1 || $urandom_range(0, 2) != 0)) begin
                rgb_vld = 1'b1;
                rgb_data = img[n_in];
            end
            #1;
            if (armed) begin
                if (rgb_busy) flush_cnt++;
                else begin
                    armed = 0;
                    if (mode == 0) check("flush_len", flush_cnt, 2*W + 2);
                end
            end
            if (st_idx > 0) begin
                check("stall_in_busy", int'(rgb_busy), 1);
                if (st_idx >= 2) begin
                    check("stall_g_vld", int'(o_result_g_vld), 1);
                    check("stall_g_hold", int'(o_result_g_data), int'(held));
                    check("stall_r_vld", int'(o_result_r_vld), 0);
                    check("stall_b_vld", int'(o_result_b_vld), 0);
                end
            end
            if (rgb_vld && !rgb_busy) begin
                acc = 1;
                n_in++;
                if (n_in % N == 0) begin
                    armed = 1;
                    flush_cnt = 0;
                end
            end
            for (int c = 0; c < 3; c++) begin
                if (ovld[c] && !sbusy[c]) begin
                    idx = n_out[c];
                    if (abort_after == 0) begin
                        if (idx >= total) begin
                            check($sformatf("extra_out ch%0d", c), idx, total - 1);
                        end else begin
                            got[c][idx] = odat[c];
                            f = idx / N;
                            p = idx % N;
                            check($sformatf("pix ch%0d f%0d (%0d,%0d)", c, f, p % W, p / W),
                                  int'(odat[c]), ref_out(c, f, p % W, p / W));
                        end
                    end
                    n_out[c]++;
                end
            end
            if (abort_after != 0) done = (n_in >= abort_after);
            else done = (n_out[0] >= total) && (n_out[1] >= total) && (n_out[2] >= total);
        end
        @(negedge clk);
        rgb_vld = 1'b0;
        sbusy = 3'b000;
        if (abort_after == 0) begin
            #1;
            check("idle_vld", int'(ovld), 0);
        end
    endtask

    task automatic fill_const(input int f, input logic [7:0] v);
        for (int i = 0; i < N; i++) img[f*N + i] = {v, v, v};
    endtask

    task automatic fill_rand(input int f);
        for (int i = 0; i < N; i++) img[f*N + i] = 24'($urandom);
    endtask

    initial begin
        rst = 1'b0;
        rgb_vld = 1'b0;
        rgb_data = 24'd0;
        sbusy = 3'b000;
        #22;
        check("rst_vld", int'(ovld), 0);
        check("rst_r_data", int'(o_result_r_data), 0);
        check("rst_g_data", int'(o_result_g_data), 0);
        check("rst_b_data", int'(o_result_b_data), 0);
        check("rst_in_busy", int'(rgb_busy), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_in_busy", int'(rgb_busy), 0);

        // constant image
        fill_const(0, 8'd100);
        run_frames(1, 0, 0);
        check("const_r_00", int'(got[0][0]), 47);
        check("const_g_1515", int'(got[1][15*W + 15]), 47);
        check("const_b_55", int'(got[2][5*W + 5]), 100);
        check("const_r_1313", int'(got[0][13*W + 13]), 100);
        check("const_g_top", int'(got[1][7]), 69);

        // impulse in R at (10,10)
        fill_const(0, 8'd0);
        img[10*W + 10] = 24'h0000FF;
        run_frames(1, 0, 0);
        check("imp_r_10_10", int'(got[0][10*W + 10]), 36);
        check("imp_r_9_10", int'(got[0][10*W + 9]), 24);
        check("imp_r_8_8", int'(got[0][8*W + 8]), 1);
        check("imp_g_10_10", int'(got[1][10*W + 10]), 0);
        check("imp_b_10_10", int'(got[2][10*W + 10]), 0);

        // G backpressure mid-stream
        fill_rand(0);
        run_frames(1, 2, 0);

        // random stalls on all handshakes over two frames
        fill_rand(0);
        fill_rand(1);
        run_frames(2, 1, 0);

        // reset in the middle of a frame, then a clean constant frame
        fill_rand(0);
        run_frames(1, 0, 100);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_vld", int'(ovld), 0);
        check("midrst_r_data", int'(o_result_r_data), 0);
        check("midrst_in_busy", int'(rgb_busy), 1);
        @(negedge clk);
        rst = 1'b1;
        fill_const(0, 8'd100);
        run_frames(1, 0, 0);
        check("midrst_r_00", int'(got[0][0]), 47);
        check("midrst_b_77", int'(got[2][7*W + 7]), 100);

        // back-to-back frames: random then constant
        fill_rand(0);
        fill_const(1, 8'd100);
        run_frames(2, 0, 0);
        check("b2b_r_00", int'(got[0][N]), 47);
        check("b2b_g_top", int'(got[1][N + 7]), 69);
        check("b2b_b_bot", int'(got[2][N + 15*W + 7]), 69);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
